// File: rtl/neopixel_strip_controller.sv
// WS2812-style strand driver: G,R,B frame buffer, per-frame brightness scaling,
// bit-timed serial output with a latch gap and optional automatic refresh.
module neopixel_strip_controller #(
  parameter int NUM_PIXELS = 8,
  parameter int IDX_W      = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1,
  parameter int T0H        = 18,
  parameter int T0L        = 40,
  parameter int T1H        = 35,
  parameter int T1L        = 30,
  parameter int TLATCH     = 2500
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic [7:0]       red,
  input  logic [7:0]       green,
  input  logic [7:0]       blue,
  input  logic [IDX_W-1:0] pixel,
  input  logic             load,
  input  logic             go,
  input  logic             auto_refresh,
  input  logic [7:0]       brightness,
  output logic             neopixel_data,
  output logic             ready,
  output logic             frame_done
);

  localparam int AW     = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int DEPTH  = 1 << AW;
  localparam int CMAX_0 = (T0H > T0L) ? T0H : T0L;
  localparam int CMAX_1 = (T1H > T1L) ? T1H : T1L;
  localparam int CMAX_2 = (CMAX_0 > CMAX_1) ? CMAX_0 : CMAX_1;
  localparam int CMAX   = (CMAX_2 > TLATCH) ? CMAX_2 : TLATCH;
  localparam int CNT_W  = $clog2(CMAX + 1);

  localparam logic [IDX_W:0]  NPIX     = (IDX_W+1)'(NUM_PIXELS);
  localparam logic [AW-1:0]   LAST_PIX = AW'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    LATCH = 3'd4
  } state_t;

  function automatic logic [7:0] scale_byte(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = {8'd0, c} * ({8'd0, b} + 16'd1);
    return prod[15:8];
  endfunction

  function automatic logic [23:0] scale_word(input logic [23:0] w, input logic [7:0] b);
    return {scale_byte(w[23:16], b), scale_byte(w[15:8], b), scale_byte(w[7:0], b)};
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        bit_q, bit_d;
  logic [AW-1:0]     pix_q, pix_d;
  logic [23:0]       shift_q, shift_d;
  logic [7:0]        bright_q, bright_d;
  logic              data_q, ready_q, done_q, done_d;
  logic [23:0]       fb_q [DEPTH];
  logic [23:0]       fetch_word_s;
  logic              wr_en_s;
  logic [AW-1:0]     wr_idx_s;

  assign wr_en_s  = load && ready_q && ({1'b0, pixel} < NPIX);
  assign wr_idx_s = AW'(pixel);

  // Frame buffer: cleared by reset, written only while idle and in range.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fb_q[i] <= 24'd0;
      end
    end else if (wr_en_s) begin
      fb_q[wr_idx_s] <= {green, red, blue};
    end
  end

  // Next-state logic for the bit-timing FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    pix_d        = pix_q;
    shift_d      = shift_q;
    bright_d     = bright_q;
    done_d       = 1'b0;
    fetch_word_s = scale_word(fb_q[pix_q], bright_q);
    case (state_q)
      IDLE: begin
        if (go || (auto_refresh && done_q)) begin
          state_d  = FETCH;
          pix_d    = '0;
          bit_d    = 5'd0;
          bright_d = brightness;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        shift_d = fetch_word_s;
        bit_d   = 5'd0;
        state_d = HIGH;
        cnt_d   = fetch_word_s[23] ? CNT_W'(T1H - 1) : CNT_W'(T0H - 1);
      end
      HIGH: begin
        if (cnt_q == '0) begin
          state_d = LOW;
          cnt_d   = shift_q[23] ? CNT_W'(T1L - 1) : CNT_W'(T0L - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      LOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (bit_q != 5'd23) begin
          // Next bit follows immediately; its polarity is the bit after the MSB.
          state_d = HIGH;
          bit_d   = bit_q + 5'd1;
          shift_d = {shift_q[22:0], 1'b0};
          cnt_d   = shift_q[22] ? CNT_W'(T1H - 1) : CNT_W'(T0H - 1);
        end else if (pix_q == LAST_PIX) begin
          state_d = LATCH;
          cnt_d   = CNT_W'(TLATCH - 1);
        end else begin
          state_d = FETCH;
          pix_d   = pix_q + AW'(1);
        end
      end
      LATCH: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset parks in FETCH so a blank frame follows release.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= FETCH;
      cnt_q    <= '0;
      bit_q    <= 5'd0;
      pix_q    <= '0;
      shift_q  <= 24'd0;
      bright_q <= 8'd0;
      data_q   <= 1'b0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      pix_q    <= pix_d;
      shift_q  <= shift_d;
      bright_q <= bright_d;
      data_q   <= (state_d == HIGH);
      ready_q  <= (state_d == IDLE);
      done_q   <= done_d;
    end
  end

  assign neopixel_data = data_q;
  assign ready         = ready_q;
  assign frame_done    = done_q;

endmodule

// File: tb/tb_neopixel_strip_controller.sv
// Testbench for neopixel_strip_controller: expected line waveforms are built
// from a pixel/brightness model and compared cycle by cycle.
module tb_neopixel_strip_controller;

  localparam int NUM_PIXELS = 8;
  localparam int IDX_W      = 4;
  localparam int T0H        = 4;
  localparam int T0L        = 9;
  localparam int T1H        = 8;
  localparam int T1L        = 6;
  localparam int TLATCH     = 300;

  logic             CLOCK_50 = 1'b0;
  logic             reset_n  = 1'b0;
  logic [7:0]       red, green, blue, brightness;
  logic [IDX_W-1:0] pixel;
  logic             load, go, auto_refresh;
  logic             neopixel_data, ready, frame_done;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_r [NUM_PIXELS];
  logic [7:0] m_g [NUM_PIXELS];
  logic [7:0] m_b [NUM_PIXELS];
  logic [7:0] m_bright;
  bit         decoded_q [$];

  neopixel_strip_controller #(
    .NUM_PIXELS(NUM_PIXELS), .IDX_W(IDX_W), .T0H(T0H), .T0L(T0L),
    .T1H(T1H), .T1L(T1L), .TLATCH(TLATCH)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .red(red), .green(green), .blue(blue),
    .pixel(pixel), .load(load), .go(go), .auto_refresh(auto_refresh),
    .brightness(brightness), .neopixel_data(neopixel_data), .ready(ready),
    .frame_done(frame_done)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  function automatic logic [7:0] m_scale(input logic [7:0] c, input logic [7:0] b);
    int v;
    v = (int'(c) * (int'(b) + 1)) / 256;
    return v[7:0];
  endfunction

  function automatic logic [23:0] m_word(input int p);
    return {m_scale(m_g[p], m_bright), m_scale(m_r[p], m_bright), m_scale(m_b[p], m_bright)};
  endfunction

  function automatic int pixel_cycles(input int p);
    logic [23:0] w;
    int n;
    w = m_word(p);
    n = 0;
    for (int i = 0; i < 24; i++) n += w[i] ? (T1H + T1L) : (T0H + T0L);
    return n;
  endfunction

  function automatic logic [23:0] dec_word(input int p);
    logic [23:0] w;
    if (decoded_q.size() < (p + 1) * 24) return 24'hxxxxxx;
    w = 24'd0;
    for (int i = 0; i < 24; i++) w = {w[22:0], decoded_q[p*24 + i]};
    return w;
  endfunction

  task automatic model_clear();
    for (int p = 0; p < NUM_PIXELS; p++) begin
      m_r[p] = 8'd0; m_g[p] = 8'd0; m_b[p] = 8'd0;
    end
    m_bright = 8'd0;
  endtask

  task automatic drive_load(input int p, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    load = 1'b1; pixel = p[IDX_W-1:0]; red = r; green = g; blue = b;
    if (p < NUM_PIXELS) begin
      m_r[p] = r; m_g[p] = g; m_b[p] = b;
    end
  endtask

  task automatic drive_go(input logic [7:0] b);
    go = 1'b1; brightness = b; m_bright = b;
  endtask

  task automatic load_all_random();
    for (int p = 0; p < NUM_PIXELS; p++) begin
      @(negedge CLOCK_50);
      drive_load(p, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    @(negedge CLOCK_50);
    load = 1'b0;
  endtask

  // Next negedge must correspond to the FETCH cycle (or the first HIGH when skip_first).
  task automatic check_wave(input string name, input bit skip_first);
    bit wave [$];
    logic [23:0] w;
    int bad, first_bad, run;
    logic obs_first, exp_first;
    wave.push_back(1'b0);
    for (int p = 0; p < NUM_PIXELS; p++) begin
      w = m_word(p);
      if (p > 0) wave.push_back(1'b0);
      for (int b = 23; b >= 0; b--) begin
        for (int k = 0; k < (w[b] ? T1H : T0H); k++) wave.push_back(1'b1);
        for (int k = 0; k < (w[b] ? T1L : T0L); k++) wave.push_back(1'b0);
      end
    end
    for (int k = 0; k < TLATCH; k++) wave.push_back(1'b0);
    bad = 0; first_bad = -1; run = 0; obs_first = 1'b0; exp_first = 1'b0;
    decoded_q.delete();
    for (int i = (skip_first ? 1 : 0); i < wave.size(); i++) begin
      @(negedge CLOCK_50);
      if (i <= 1) begin
        go = 1'b0; load = 1'b0;
      end
      if (neopixel_data !== wave[i] || ready !== 1'b0 || frame_done !== 1'b0) begin
        if (bad == 0) begin
          first_bad = i; obs_first = neopixel_data; exp_first = wave[i];
        end
        bad++;
      end
      if (neopixel_data === 1'b1) run++;
      else if (run > 0) begin
        decoded_q.push_back(run == T1H);
        run = 0;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s waveform: %0d cycles wrong, first at cycle %0d (line=%0b, required %0b, ready/frame_done must be 0)",
               name, bad, first_bad, obs_first, exp_first);
    end
    @(negedge CLOCK_50);
    checks++;
    if (frame_done !== 1'b1 || ready !== 1'b1) begin
      failures++;
      $display("FAIL %s end: frame_done=%0b ready=%0b, required frame_done=1 ready=1", name, frame_done, ready);
    end
  endtask

  task automatic check_idle(input string name, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLOCK_50);
      if (ready !== 1'b1 || neopixel_data !== 1'b0 || frame_done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s: %0d of %0d idle cycles not (ready=1 line=0 frame_done=0), required 0", name, bad, n);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    checks++;
    if ({neopixel_data, ready, frame_done} !== 3'b000) begin
      failures++;
      $display("FAIL reset_outputs: data/ready/done=%b, required 000", {neopixel_data, ready, frame_done});
    end
    model_clear();
    reset_n = 1'b1;
    check_wave("reset_frame", 1'b1);
    check_idle("after_reset_idle", 4);
  endtask

  task automatic test_spec_pattern();
    @(negedge CLOCK_50);
    drive_load(0, 8'hFF, 8'h00, 8'h81);
    drive_go(8'd255);
    check_wave("spec_b255", 1'b0);
    checks++;
    if (dec_word(0) !== 24'h00FF81) begin
      failures++;
      $display("FAIL spec_b255_bits: got %h, required 00ff81", dec_word(0));
    end
    @(negedge CLOCK_50);
    drive_go(8'd127);
    check_wave("spec_b127", 1'b0);
    checks++;
    if (dec_word(0) !== 24'h007F40) begin
      failures++;
      $display("FAIL spec_b127_bits: got %h, required 007f40", dec_word(0));
    end
  endtask

  task automatic test_ignored_writes();
    @(negedge CLOCK_50);
    drive_load(9, 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)));
    @(negedge CLOCK_50);
    load = 1'b0;
    @(negedge CLOCK_50);
    drive_go(8'd127);
    fork
      check_wave("out_of_range_load", 1'b0);
      begin
        repeat (20) @(negedge CLOCK_50);
        load = 1'b1; pixel = 4'd2; red = 8'hA5; green = 8'h5A; blue = 8'hC3; go = 1'b1;
        @(negedge CLOCK_50);
        load = 1'b0; go = 1'b0;
      end
    join
    check_idle("go_not_queued", 6);
    @(negedge CLOCK_50);
    drive_go(8'd255);
    check_wave("busy_load_ignored", 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int it = 0; it < 3; it++) begin
      load_all_random();
      b = (it == 0) ? 8'd0 : 8'($urandom_range(1, 254));
      @(negedge CLOCK_50);
      drive_go(b);
      fork
        check_wave($sformatf("random_%0d", it), 1'b0);
        begin
          repeat (50) @(negedge CLOCK_50);
          brightness = 8'($urandom_range(0, 255));
        end
      join
    end
  endtask

  task automatic test_auto_refresh();
    @(negedge CLOCK_50);
    auto_refresh = 1'b1;
    drive_go(8'($urandom_range(0, 255)));
    check_wave("auto_frame1", 1'b0);
    fork
      check_wave("auto_frame2", 1'b0);
      begin
        repeat (100) @(negedge CLOCK_50);
        auto_refresh = 1'b0;
      end
    join
    check_idle("auto_stopped", 6);
  endtask

  task automatic test_reset_mid_frame();
    int target;
    load_all_random();
    @(negedge CLOCK_50);
    drive_go(8'd255);
    target = 1 + pixel_cycles(0) + pixel_cycles(1) + pixel_cycles(2) + 3 + 10;
    @(negedge CLOCK_50);
    go = 1'b0;
    repeat (target - 1) @(negedge CLOCK_50);
    for (int i = 0; i < 40 && neopixel_data !== 1'b1; i++) @(negedge CLOCK_50);
    checks++;
    if (neopixel_data !== 1'b1) begin
      failures++;
      $display("FAIL mid_frame_high: line=%0b in pixel 3, required 1", neopixel_data);
    end
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if ({neopixel_data, ready, frame_done} !== 3'b000) begin
      failures++;
      $display("FAIL async_abort: data/ready/done=%b, required 000", {neopixel_data, ready, frame_done});
    end
    repeat (3) @(negedge CLOCK_50);
    model_clear();
    reset_n = 1'b1;
    check_wave("post_reset_frame", 1'b1);
    @(negedge CLOCK_50);
    drive_go(8'd255);
    check_wave("buffer_cleared", 1'b0);
  endtask

  initial begin
    red = 8'd0; green = 8'd0; blue = 8'd0; brightness = 8'd0; pixel = '0;
    load = 1'b0; go = 1'b0; auto_refresh = 1'b0;
    model_clear();
    test_reset();
    test_spec_pattern();
    test_ignored_writes();
    test_random();
    test_auto_refresh();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/neopixel_strip_controller.md
NEOPIXEL_STRIP_CONTROLLER -- requirements
Module: neopixel_strip_controller

Interface
REQ-001 Parameter NUM_PIXELS, default 8: number of NeoPixels on the strand, legal range 1-256.
REQ-002 Parameter IDX_W, default $clog2(NUM_PIXELS) (minimum 1): width of the pixel index.
REQ-003 Parameters T0H/T0L/T1H/T1L, defaults 18/40/35/30: CLOCK_50 cycles for the high and low phases of a 0 bit and a 1 bit.
REQ-004 Parameter TLATCH, default 2500: number of low cycles after the last bit of a frame.
REQ-005 Port CLOCK_50, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 Ports red, green, blue, inputs, 8 bits each: colour for a pixel write.
REQ-008 Port pixel, input, IDX_W bits: index of the pixel to write.
REQ-009 Port load, input, 1 bit: write the colour into the frame buffer at pixel.
REQ-010 Port go, input, 1 bit: start transmitting a frame.
REQ-011 Port auto_refresh, input, 1 bit: restart transmission automatically after each frame.
REQ-012 Port brightness, input, 8 bits: global brightness scale applied to the frame.
REQ-013 Port neopixel_data, output, 1 bit: registered serial line to the strand.
REQ-014 Port ready, output, 1 bit: high when in IDLE; load and go are accepted only while ready is high.
REQ-015 Port frame_done, output, 1 bit: one-cycle pulse at the end of each frame.

Function
REQ-016 The frame buffer SHALL hold NUM_PIXELS x 24 bits, stored in G,R,B byte order.
REQ-017 A write SHALL occur when load=1 and ready=1; it is ignored if pixel >= NUM_PIXELS or ready=0.
REQ-018 The FSM SHALL have exactly these states: IDLE, FETCH, HIGH, LOW, LATCH.
REQ-019 IDLE SHALL move to FETCH when go=1, or when auto_refresh=1 and the previous frame has just completed.
REQ-020 The brightness value SHALL be captured at the IDLE->FETCH edge and held constant for the whole frame.
REQ-021 If load and go are both high in the same ready cycle, the written data SHALL appear in that frame.
REQ-022 FETCH SHALL last exactly one cycle and load the 24-bit word for the current pixel into a shift register.
REQ-023 Each byte in FETCH SHALL be scaled as (c*(brightness+1))>>8, using 16-bit intermediate arithmetic.
REQ-024 Scaling SHALL give identity at brightness=255 and all zeros at brightness=0.
REQ-025 Transmission order SHALL be pixel 0 first, and MSB first within each of G, R and B.
REQ-026 The first HIGH cycle SHALL begin 2 cycles after go is sampled: one cycle in FETCH, then HIGH.
REQ-027 HIGH SHALL drive neopixel_data=1 for exactly T1H cycles for a 1 bit, or T0H cycles for a 0 bit.
REQ-028 LOW SHALL drive neopixel_data=0 for exactly T1L or T0L cycles, matching the current bit.
REQ-029 After LOW, the next bit's HIGH SHALL start with no gap cycles.
REQ-030 After the 24th bit of a pixel, the FSM SHALL pass through FETCH for 1 cycle (line held low) before the next pixel's HIGH.
REQ-031 After the last bit of the last pixel, the FSM SHALL enter LATCH and hold neopixel_data=0 for TLATCH cycles.
REQ-032 At the end of LATCH, the FSM SHALL return to IDLE with frame_done=1 and ready=1 in that IDLE cycle.
REQ-033 If auto_refresh=1 in that IDLE cycle, the next frame SHALL start as if go had been asserted.
REQ-034 go asserted while ready=0 SHALL be ignored and not queued.
REQ-035 The pixel counter and bit counter SHALL use no wrap-around beyond NUM_PIXELS-1 and 23.
REQ-036 A NUM_PIXELS=1 strand SHALL work with the same rules.

Reset
REQ-037 While reset_n=0, the SHALL state is reset, the frame buffer is all zeros, and the outputs are neopixel_data=0, ready=0, frame_done=0.
REQ-038 On reset release, the block SHALL automatically transmit one all-zero frame with ready=0, then enter IDLE.
REQ-039 Reset asserted mid-frame SHALL abort immediately: the line goes low and the post-reset blank frame follows.

Verification
REQ-040 Release reset with NUM_PIXELS=8 -> 192 zero bits (58 cycles each) plus 7 FETCH gaps plus 1 initial FETCH plus 2500 LATCH cycles, then frame_done pulses once and ready=1.
REQ-041 Load pixel 0 = R8'hFF, G8'h00, B8'h81 with go in the same cycle, brightness=255 -> bits 00000000 11111111 10000001; 1 bits show 35-high/30-low and 0 bits show 18-high/40-low.
REQ-042 Same data with brightness=127 -> transmitted bytes 8'h00, 8'h7F, 8'h40.
REQ-043 load with pixel=9 and NUM_PIXELS=8, then go -> frame identical to the previous one; load while ready=0 -> no buffer change.
REQ-044 Set auto_refresh=1 and pulse go once -> back-to-back frames, frame_done each frame, one IDLE cycle between LATCH and FETCH.
REQ-045 Drop reset_n during pixel 3 -> line goes low asynchronously, then an all-zero frame follows, and the buffer reads all zeros.
